// File: rtl/tower_object_ctrl.sv
// Tower object controller: spawn/hit/blink/destroy lifecycle and
// rectangle hit-test with registered bitmap offsets for one tower sprite.
module tower_object_ctrl #(
  parameter int unsigned OBJECT_WIDTH_X  = 28,
  parameter int unsigned OBJECT_HEIGHT_Y = 58,
  parameter int unsigned HIT_POINTS      = 3,
  parameter int unsigned BLINK_FRAMES    = 16
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        spawn,
  input  logic [10:0] spawnX,
  input  logic [10:0] spawnY,
  input  logic        hit,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic        alive,
  output logic        destroyed
);

  localparam int unsigned HW_RAW = $clog2(HIT_POINTS + 1);
  localparam int unsigned HW     = (HW_RAW < 1) ? 1 : HW_RAW;
  localparam int unsigned FW_RAW = $clog2(BLINK_FRAMES + 1);
  // frameCnt[1] drives the blink, so keep at least two bits
  localparam int unsigned FW     = (FW_RAW < 2) ? 2 : FW_RAW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DYING  = 2'd2,
    DEAD   = 2'd3
  } state_t;

  state_t        state;
  logic [HW-1:0] health;
  logic [FW-1:0] frameCnt;
  logic          spawnPending;
  logic [10:0]   pendX;
  logic [10:0]   pendY;
  logic [10:0]   topLeftX;
  logic [10:0]   topLeftY;
  logic          hitTaken;

  logic          hitTakenEff;
  logic          countHit;
  logic [11:0]   rightEdge;
  logic [11:0]   bottomEdge;
  logic          insideNow;
  logic          drawEnable;
  logic          drawPixel;

  // Hit qualification: a start-of-frame reopens the per-frame hit window in the same cycle
  always_comb begin
    hitTakenEff = hitTaken & ~startOfFrame;
    countHit    = hit & ~hitTakenEff;
  end

  // Rectangle test with 12-bit edges so objects near 2047 clip instead of wrapping
  always_comb begin
    rightEdge  = {1'b0, topLeftX} + 12'(OBJECT_WIDTH_X);
    bottomEdge = {1'b0, topLeftY} + 12'(OBJECT_HEIGHT_Y);
    insideNow  = (pixelX >= topLeftX) && ({1'b0, pixelX} < rightEdge) &&
                 (pixelY >= topLeftY) && ({1'b0, pixelY} < bottomEdge);
    drawEnable = (state == ACTIVE) || ((state == DYING) && !frameCnt[1]);
    drawPixel  = insideNow && drawEnable;
  end

  // Lifecycle FSM with registered alive/destroyed
  always_ff @(posedge clk) begin
    if (resetN) begin
      state        <= IDLE;
      health       <= '0;
      frameCnt     <= '0;
      spawnPending <= 1'b0;
      pendX        <= '0;
      pendY        <= '0;
      topLeftX     <= '0;
      topLeftY     <= '0;
      hitTaken     <= 1'b0;
      alive        <= 1'b0;
      destroyed    <= 1'b0;
    end else begin
      destroyed <= 1'b0;
      unique case (state)
        IDLE, DEAD: begin
          if (spawnPending && startOfFrame) begin
            state        <= ACTIVE;
            topLeftX     <= pendX;
            topLeftY     <= pendY;
            health       <= HW'(HIT_POINTS);
            spawnPending <= 1'b0;
            hitTaken     <= 1'b0;
            alive        <= 1'b1;
          end else if (spawn) begin
            pendX        <= spawnX;
            pendY        <= spawnY;
            spawnPending <= 1'b1;
          end
        end
        ACTIVE: begin
          if (countHit) begin
            hitTaken <= 1'b1;
            health   <= health - HW'(1);
            if (health == HW'(1)) begin
              state    <= DYING;
              frameCnt <= FW'(BLINK_FRAMES);
              alive    <= 1'b0;
            end
          end else begin
            hitTaken <= hitTakenEff;
          end
        end
        DYING: begin
          if (startOfFrame) begin
            frameCnt <= frameCnt - FW'(1);
            if (frameCnt == FW'(1)) begin
              state     <= DEAD;
              destroyed <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered draw outputs, one cycle behind the pixel coordinate
  always_ff @(posedge clk) begin
    if (resetN) begin
      InsideRectangle <= 1'b0;
      offsetX         <= '0;
      offsetY         <= '0;
    end else begin
      InsideRectangle <= drawPixel;
      offsetX         <= drawPixel ? (pixelX - topLeftX) : '0;
      offsetY         <= drawPixel ? (pixelY - topLeftY) : '0;
    end
  end

endmodule

// File: tb/tb_tower_object_ctrl.sv
// Directed scoreboard bench for tower_object_ctrl.
module tb_tower_object_ctrl;

  logic        clk;
  logic        resetN;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic        spawn;
  logic [10:0] spawnX;
  logic [10:0] spawnY;
  logic        hit;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        InsideRectangle;
  logic        alive;
  logic        destroyed;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        ins;
    logic [10:0] ox;
    logic [10:0] oy;
  } exp_t;

  exp_t sbq[$];

  tower_object_ctrl #(
    .OBJECT_WIDTH_X (28),
    .OBJECT_HEIGHT_Y(58),
    .HIT_POINTS     (3),
    .BLINK_FRAMES   (16)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .startOfFrame   (startOfFrame),
    .spawn          (spawn),
    .spawnX         (spawnX),
    .spawnY         (spawnY),
    .hit            (hit),
    .offsetX        (offsetX),
    .offsetY        (offsetY),
    .InsideRectangle(InsideRectangle),
    .alive          (alive),
    .destroyed      (destroyed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic do_spawn(input logic [10:0] x, input logic [10:0] y);
    spawn  = 1'b1;
    spawnX = x;
    spawnY = y;
    tick();
    spawn  = 1'b0;
  endtask

  task automatic hit_pulse();
    hit = 1'b1;
    tick();
    hit = 1'b0;
    tick();
  endtask

  // Drive a pixel, queue its expected registered result, compare on the next cycle
  task automatic pix(input logic [10:0] x, input logic [10:0] y, input logic ei,
                     input logic [10:0] ex, input logic [10:0] ey, input string tag);
    exp_t e;
    exp_t got;
    pixelX = x;
    pixelY = y;
    e.tag = tag;
    e.ins = ei;
    e.ox  = ex;
    e.oy  = ey;
    sbq.push_back(e);
    tick();
    if (sbq.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      got = sbq.pop_front();
      chk({got.tag, "_ins"}, {31'd0, InsideRectangle}, {31'd0, got.ins});
      chk({got.tag, "_ox"},  {21'd0, offsetX}, {21'd0, got.ox});
      chk({got.tag, "_oy"},  {21'd0, offsetY}, {21'd0, got.oy});
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ins"},  {31'd0, InsideRectangle}, 32'd0);
    chk({tag, "_ox"},   {21'd0, offsetX}, 32'd0);
    chk({tag, "_oy"},   {21'd0, offsetY}, 32'd0);
    chk({tag, "_alive"}, {31'd0, alive}, 32'd0);
    chk({tag, "_destr"}, {31'd0, destroyed}, 32'd0);
  endtask

  initial begin
    logic on;
    // Reset with every other input busy
    resetN       = 1'b1;
    pixelX       = 11'd100;
    pixelY       = 11'd200;
    startOfFrame = 1'b1;
    spawn        = 1'b1;
    spawnX       = 11'd100;
    spawnY       = 11'd200;
    hit          = 1'b1;
    tick();
    tick();
    chk_all_zero("reset");
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    spawn        = 1'b0;
    hit          = 1'b0;
    sof();
    chk("reset_no_pending", {31'd0, alive}, 32'd0);
    pix(11'd0, 11'd0, 1'b0, 11'd0, 11'd0, "idle_origin");

    // Spawn at (100,200)
    do_spawn(11'd100, 11'd200);
    pix(11'd100, 11'd200, 1'b0, 11'd0, 11'd0, "pending_nodraw");
    chk("pending_alive", {31'd0, alive}, 32'd0);
    sof();
    chk("spawn_alive", {31'd0, alive}, 32'd1);
    pix(11'd100, 11'd200, 1'b1, 11'd0,  11'd0,  "tl_corner");
    pix(11'd127, 11'd257, 1'b1, 11'd27, 11'd57, "br_corner");
    pix(11'd128, 11'd200, 1'b0, 11'd0,  11'd0,  "right_out");
    pix(11'd99,  11'd200, 1'b0, 11'd0,  11'd0,  "left_out");
    pix(11'd100, 11'd258, 1'b0, 11'd0,  11'd0,  "bottom_out");
    pix(11'd110, 11'd199, 1'b0, 11'd0,  11'd0,  "top_out");

    // Spawn while ACTIVE is ignored
    do_spawn(11'd500, 11'd500);
    sof();
    pix(11'd100, 11'd200, 1'b1, 11'd0, 11'd0, "ign_spawn_old");
    pix(11'd500, 11'd500, 1'b0, 11'd0, 11'd0, "ign_spawn_new");

    // Hit held high across three frames
    hit = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("held_f1_alive", {31'd0, alive}, 32'd1);
    sof();
    tick();
    tick();
    tick();
    chk("held_f2_alive", {31'd0, alive}, 32'd1);
    sof();
    chk("held_f3_dying", {31'd0, alive}, 32'd0);
    hit = 1'b0;

    // Blink sequence through DYING into DEAD
    pix(11'd100, 11'd200, 1'b1, 11'd0, 11'd0, "blink_k0");
    chk("blink_k0_destr", {31'd0, destroyed}, 32'd0);
    for (int k = 1; k <= 16; k++) begin
      sof();
      chk($sformatf("blink_k%0d_destr", k), {31'd0, destroyed}, (k == 16) ? 32'd1 : 32'd0);
      on = (k < 16) && !((k % 4) == 1 || (k % 4) == 2);
      pix(11'd100, 11'd200, on, 11'd0, 11'd0, $sformatf("blink_k%0d", k));
    end
    chk("dead_destr_low", {31'd0, destroyed}, 32'd0);
    chk("dead_alive", {31'd0, alive}, 32'd0);
    hit_pulse();
    sof();
    pix(11'd100, 11'd200, 1'b0, 11'd0, 11'd0, "dead_nodraw");

    // Spawn coincident with start-of-frame in DEAD, placed at the screen edge
    spawn        = 1'b1;
    spawnX       = 11'd2030;
    spawnY       = 11'd2040;
    startOfFrame = 1'b1;
    tick();
    spawn        = 1'b0;
    startOfFrame = 1'b0;
    chk("coinc_not_yet", {31'd0, alive}, 32'd0);
    pix(11'd2047, 11'd2047, 1'b0, 11'd0, 11'd0, "coinc_nodraw");
    sof();
    chk("coinc_active", {31'd0, alive}, 32'd1);
    pix(11'd2047, 11'd2047, 1'b1, 11'd17, 11'd7, "edge_max");
    pix(11'd0,    11'd0,    1'b0, 11'd0,  11'd0, "edge_nowrap");
    pix(11'd10,   11'd2045, 1'b0, 11'd0,  11'd0, "edge_nowrap_x");
    pix(11'd2029, 11'd2047, 1'b0, 11'd0,  11'd0, "edge_left_out");
    pix(11'd2030, 11'd2040, 1'b1, 11'd0,  11'd0, "edge_tl");

    // Two hit pulses in one frame count once
    hit_pulse();
    hit_pulse();
    chk("dbl_f1_alive", {31'd0, alive}, 32'd1);
    sof();
    hit_pulse();
    chk("dbl_f2_alive", {31'd0, alive}, 32'd1);
    sof();
    hit_pulse();
    chk("dbl_f3_dying", {31'd0, alive}, 32'd0);

    // Reset in the middle of DYING
    pix(11'd2030, 11'd2040, 1'b1, 11'd0, 11'd0, "predeath_draw");
    resetN = 1'b1;
    spawn  = 1'b1;
    spawnX = 11'd10;
    spawnY = 11'd10;
    tick();
    chk_all_zero("midreset");
    resetN = 1'b0;
    spawn  = 1'b0;
    sof();
    chk("midreset_idle", {31'd0, alive}, 32'd0);
    pix(11'd2030, 11'd2040, 1'b0, 11'd0, 11'd0, "midreset_nodraw");
    pix(11'd0,    11'd0,    1'b0, 11'd0, 11'd0, "midreset_origin");
    do_spawn(11'd10, 11'd10);
    sof();
    chk("respawn_alive", {31'd0, alive}, 32'd1);
    pix(11'd10, 11'd10, 1'b1, 11'd0,  11'd0,  "respawn_tl");
    pix(11'd37, 11'd67, 1'b1, 11'd27, 11'd57, "respawn_br");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tower_object_ctrl.md
TOWER_OBJECT_CTRL -- requirements
Module: tower_object_ctrl

Interface
REQ-001 SHALL have parameter OBJECT_WIDTH_X, default 28, drawn width in pixels (bitmap width 14 scaled x2).
REQ-002 SHALL have parameter OBJECT_HEIGHT_Y, default 58, drawn height in pixels (bitmap height 29 scaled x2).
REQ-003 SHALL have parameter HIT_POINTS, default 3, hits needed to destroy the tower.
REQ-004 SHALL have parameter BLINK_FRAMES, default 16, length of the dying phase in frames.
REQ-005 SHALL have port clk  in  1  system clock; all logic on the rising edge.
REQ-006 SHALL have port resetN  in  1  reset; synchronous, active-high (asserted = 1).
REQ-007 SHALL have ports pixelX, pixelY  in  11 each  current VGA pixel coordinate.
REQ-008 SHALL have port startOfFrame  in  1  one-cycle pulse at frame start.
REQ-009 SHALL have port spawn  in  1  request to place a new tower.
REQ-010 SHALL have ports spawnX, spawnY  in  11 each  requested top-left position; sampled with spawn.
REQ-011 SHALL have port hit  in  1  collision with the tower; level or pulse.
REQ-012 SHALL have ports offsetX, offsetY  out  11 each  pixel offset from the tower top-left, fed to the bitmap.
REQ-013 SHALL have port InsideRectangle  out  1  current pixel is inside the drawn tower.
REQ-014 SHALL have port alive  out  1  tower is in ACTIVE.
REQ-015 SHALL have port destroyed  out  1  one-cycle pulse when DYING ends.

Function
REQ-016 SHALL implement states IDLE, ACTIVE, DYING and DEAD.
REQ-017 SHALL accept spawn only in IDLE or DEAD: latch spawnX/spawnY into a pending register and set spawnPending; spawn in ACTIVE or DYING is ignored.
REQ-018 SHALL move from IDLE/DEAD to ACTIVE on the first startOfFrame strictly after the cycle where spawnPending was set, load topLeftX/Y from the pending register, set health=HIT_POINTS and clear spawnPending.
REQ-019 SHALL treat spawn that coincides with startOfFrame as pending, taking effect at the following startOfFrame; a later spawn before activation overwrites the pending coordinates.
REQ-020 SHALL, in ACTIVE, decrement health on hit at most once per frame; a hitTaken flag is set on the counted hit and cleared on startOfFrame.
REQ-021 SHALL, when hit and startOfFrame occur in the same cycle, clear hitTaken first and count that hit toward the new frame.
REQ-022 SHALL move ACTIVE -> DYING on the same edge that health goes from 1 to 0, and load frameCnt=BLINK_FRAMES.
REQ-023 SHALL, in DYING, decrement frameCnt on each startOfFrame and draw only while frameCnt[1] = 0 (blink every 2 frames).
REQ-024 SHALL move DYING -> DEAD on the startOfFrame where frameCnt is 1, and pulse destroyed high for exactly that transition cycle.
REQ-025 SHALL ignore hit in IDLE, DYING and DEAD.
REQ-026 SHALL compute inside = pixelX>=topLeftX, pixelX<topLeftX+OBJECT_WIDTH_X, pixelY>=topLeftY and pixelY<topLeftY+OBJECT_HEIGHT_Y, with sums formed at 12 bits (no wrap; object clipped at 2047).
REQ-027 SHALL register outputs with latency 1: at cycle t+1, InsideRectangle = inside(t) AND drawEnable(t), where drawEnable = ACTIVE, or DYING with the blink bit clear.
REQ-028 SHALL register offsetX = pixelX-topLeftX and offsetY = pixelY-topLeftY when inside AND drawEnable, else 0.
REQ-029 SHALL register alive, which is 1 exactly while state = ACTIVE.

Reset
REQ-030 SHALL, with resetN=1 at a clock edge, go to state IDLE on that edge, including when reset arrives mid-DYING or with a spawn pending.
REQ-031 SHALL, on reset, clear health, frameCnt, spawnPending, hitTaken and topLeftX/Y to 0.
REQ-032 SHALL, on reset, drive InsideRectangle=0, offsetX=offsetY=0, alive=0 and destroyed=0.
REQ-033 SHALL ignore all other inputs while resetN=1.

Verification
REQ-034 SHALL cover spawn: spawn at (100,200), then startOfFrame -> alive=1; pixel (100,200) -> InsideRectangle=1, offset (0,0) next cycle; pixel (127,257) -> offset (27,57); pixel (128,200) -> InsideRectangle=0, offset (0,0).
REQ-035 SHALL cover hit counting: hit held high 3 full frames -> health 3->2->1->0, DYING entered on the third frame; hit pulsed twice in one frame -> only one decrement.
REQ-036 SHALL cover dying/blink: after entering DYING, 16 startOfFrame pulses -> draw pattern 2 off, 2 on, repeating; destroyed high for exactly 1 cycle on the 16th pulse; state DEAD, InsideRectangle=0 thereafter.
REQ-037 SHALL cover edge placement: spawn at (2030,2040) -> pixel (2047,2047) inside with offset (17,7); no wrap to low coordinates (pixel (0,0) never inside).
REQ-038 SHALL cover ignored spawn and coincidence: spawn during ACTIVE -> position unchanged; spawn coincident with startOfFrame in DEAD -> ACTIVE only at the next startOfFrame.
REQ-039 SHALL cover mid-operation reset: resetN=1 mid-DYING -> all outputs 0 next cycle and IDLE; a new spawn is then required to draw.
